pipeline_hazard_ctrl: RTL

// Central hazard controller for the 5-stage RV64 pipeline. Replaces the separate hazard

---
 rtl/pipeline_hazard_ctrl_if.sv | 48 ++++
 rtl/pipeline_hazard_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller signal bundle. The pipeline side (master) drives the stage
// register fields and receives the hold/bubble/flush/forward controls.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_mc;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_regwrite;
    logic              branch_taken;

    logic              pc_hold;
    logic              ifid_hold;
    logic              idex_bubble;
    logic              ex_hold;
    logic              exmem_bubble;
    logic              flush_ifid;
    logic              flush_idex;
    logic              flush_exmem;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2,
        output ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_mc,
        output mem_rd, mem_regwrite, wb_rd, wb_regwrite, branch_taken,
        input  pc_hold, ifid_hold, idex_bubble, ex_hold, exmem_bubble,
        input  flush_ifid, flush_idex, flush_exmem, fwd_a, fwd_b
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2,
        input  ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_mc,
        input  mem_rd, mem_regwrite, wb_rd, wb_regwrite, branch_taken,
        output pc_hold, ifid_hold, idex_bubble, ex_hold, exmem_bubble,
        output flush_ifid, flush_idex, flush_exmem, fwd_a, fwd_b
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: operand forwarding,
// load-use stalls, multi-cycle EX occupancy, branch flush and perf counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no hazard in progress; detects load-use / multi-cycle op
// LDSTALL | extra load-use bubbles beyond the detect cycle
// MCBUSY  | multi-cycle op still occupying EX beyond the entry cycle
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int LOAD_LAT     = 1,
    parameter int MC_LAT       = 4,
    parameter int BRANCH_STAGE = 3,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0]      cnt_stall,
    output logic [CNT_W-1:0]      cnt_flush
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LDSTALL = 2'd1,
        S_MCBUSY  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       load_use;
    logic       stall_ld;
    logic       stall_mc;
    logic       pc_hold_w;
    logic       flush_w;

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use = hz.ex_memread && (hz.ex_rd != '0) &&
                   ((hz.id_use1 && (hz.id_rs1 == hz.ex_rd)) ||
                    (hz.id_use2 && (hz.id_rs2 == hz.ex_rd)));
    end

    // State register and remaining-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the counter holds cycles left after the current one, so the
    // detect/entry cycle plus the counted cycles give LOAD_LAT / MC_LAT in total.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_ld = 1'b0;
        stall_mc = 1'b0;
        if (hz.branch_taken) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hz.ex_mc) begin
                        stall_mc = 1'b1;
                        state_d  = S_MCBUSY;
                        cnt_d    = 7'(MC_LAT - 2);
                    end else if (load_use) begin
                        stall_ld = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = S_LDSTALL;
                            cnt_d   = 7'(LOAD_LAT - 2);
                        end
                    end
                end
                S_LDSTALL: begin
                    stall_ld = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
                S_MCBUSY: begin
                    stall_mc = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Pipeline controls; everything is forced quiet while reset is held.
    always_comb begin
        pc_hold_w       = 1'b0;
        flush_w         = 1'b0;
        hz.pc_hold      = 1'b0;
        hz.ifid_hold    = 1'b0;
        hz.idex_bubble  = 1'b0;
        hz.ex_hold      = 1'b0;
        hz.exmem_bubble = 1'b0;
        hz.flush_ifid   = 1'b0;
        hz.flush_idex   = 1'b0;
        hz.flush_exmem  = 1'b0;
        if (!reset) begin
            pc_hold_w       = stall_ld || stall_mc;
            flush_w         = hz.branch_taken;
            hz.pc_hold      = pc_hold_w;
            hz.ifid_hold    = pc_hold_w;
            hz.idex_bubble  = stall_ld;
            hz.ex_hold      = stall_mc;
            hz.exmem_bubble = stall_mc;
            hz.flush_ifid   = flush_w;
            hz.flush_idex   = flush_w;
            hz.flush_exmem  = flush_w && (BRANCH_STAGE == 3);
        end
    end

    // Operand forwarding: MEM is younger than WB so it wins; x0 never forwards.
    always_comb begin
        hz.fwd_a = 2'b00;
        hz.fwd_b = 2'b00;
        if (!reset) begin
            if (hz.mem_regwrite && (hz.mem_rd != '0) && (hz.mem_rd == hz.ex_rs1)) begin
                hz.fwd_a = 2'b10;
            end else if (hz.wb_regwrite && (hz.wb_rd != '0) && (hz.wb_rd == hz.ex_rs1)) begin
                hz.fwd_a = 2'b01;
            end
            if (hz.mem_regwrite && (hz.mem_rd != '0) && (hz.mem_rd == hz.ex_rs2)) begin
                hz.fwd_b = 2'b10;
            end else if (hz.wb_regwrite && (hz.wb_rd != '0) && (hz.wb_rd == hz.ex_rs2)) begin
                hz.fwd_b = 2'b01;
            end
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_stall <= '0;
            cnt_flush <= '0;
        end else begin
            if (pc_hold_w && (cnt_stall != '1)) begin
                cnt_stall <= cnt_stall + CNT_W'(1);
            end
            if (flush_w && (cnt_flush != '1)) begin
                cnt_flush <= cnt_flush + CNT_W'(1);
            end
        end
    end

endmodule
